// File: rtl/tb_uart_pkg.sv
// Shared definitions for the serial-console monitor: receiver FSM state encoding,
// firmware checkpoint codes and the newline character.
package tb_uart_pkg;

  // Receiver FSM states; plain logic constants keep the encoding visible in waves.
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t StIdle  = 3'd0;
  localparam rx_state_t StStart = 3'd1;
  localparam rx_state_t StData  = 3'd2;
  localparam rx_state_t StStop  = 3'd3;
  localparam rx_state_t StBreak = 3'd4;

  // Checkpoint codes written by firmware to mprj_io[31:16].
  localparam logic [15:0] CHK_STARTED = 16'hA000;
  localparam logic [15:0] CHK_PASSED  = 16'hAB00;

  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/tb_uart_if.sv
// Received-character stream of the console monitor.
//   rx_data      last correctly received byte
//   rx_valid     one-cycle strobe when rx_data updates
//   rx_newline   one-cycle strobe with rx_valid when the byte is LF
//   rx_frame_err one-cycle strobe when a stop bit was sampled low
//   rx_count     number of valid bytes received (wraps)
// master: the monitor driving the stream; slave: a consumer of it.
interface tb_uart_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_newline;
  logic             rx_frame_err;
  logic [CNT_W-1:0] rx_count;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_newline,
    output rx_frame_err,
    output rx_count
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_newline,
    input rx_frame_err,
    input rx_count
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and shift register.
//   core_clk   system clock
//   core_rst   synchronous active-high reset
//   ser_rx     asynchronous serial line (idles high)
//   byte_data  last byte received with a good stop bit
//   byte_valid one-cycle strobe when byte_data updates
//   frame_err  one-cycle strobe when the stop bit is sampled low
//   busy       FSM is not idle
module uart_rx_core
  import tb_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4167
) (
  input  logic       core_clk,
  input  logic       core_rst,
  input  logic       ser_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BitLast  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0] HalfLast = BaudW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q, rx_s_q;
  rx_state_t       state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (baud_q == HalfLast) begin
          // Still low at mid start bit: a real character, otherwise a glitch.
          if (!rx_s_q) begin
            state_d   = StData;
            baud_d    = '0;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_q == BitLast) begin
          baud_d    = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_q == BitLast) begin
          // Sampled mid stop bit; returning to idle here lets a start bit that
          // follows immediately be caught.
          baud_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StBreak: begin
        // Held-low line: only one frame error until the line recovers.
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= ser_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign byte_data  = data_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: rtl/tb_uart.sv
// Serial-console monitor for Caravel bring-up: receives 8N1 characters from ser_tx,
// counts them, flags newlines and framing errors, and watches the checkpoint bus.
//   core_clk     system clock
//   core_rst     synchronous active-high reset
//   ser_rx       UART line from the chip (idles high)
//   checkbits    firmware checkpoint bus, synchronous to core_clk
//   rx_bus       received-character stream (master side)
//   rx_busy      receiver FSM not idle
//   test_started sticky: checkbits seen equal to CHK_STARTED
//   test_passed  sticky: checkbits seen equal to CHK_PASSED
module tb_uart
  import tb_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4167,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        ser_rx,
  input  logic [15:0] checkbits,
  tb_uart_if.master   rx_bus,
  output logic        rx_busy,
  output logic        test_started,
  output logic        test_passed
);

  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             frame_err;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      chk_q;
  logic             started_q, passed_q;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_core (
    .core_clk  (core_clk),
    .core_rst  (core_rst),
    .ser_rx    (ser_rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (rx_busy)
  );

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      count_q   <= '0;
      chk_q     <= '0;
      started_q <= 1'b0;
      passed_q  <= 1'b0;
    end else begin
      if (byte_valid) count_q <= count_q + 1'b1;
      chk_q     <= checkbits;
      started_q <= started_q | (chk_q == CHK_STARTED);
      passed_q  <= passed_q | (chk_q == CHK_PASSED);
    end
  end

  assign rx_bus.rx_data      = byte_data;
  assign rx_bus.rx_valid     = byte_valid;
  assign rx_bus.rx_newline   = byte_valid & (byte_data == ASCII_LF);
  assign rx_bus.rx_frame_err = frame_err;
  assign rx_bus.rx_count     = count_q;
  assign test_started        = started_q;
  assign test_passed         = passed_q;

endmodule

// File: tb/tb_tb_uart.sv
// Scoreboard bench for the console monitor at 16 clocks per bit.
module tb_tb_uart;
  import tb_uart_pkg::*;

  localparam int unsigned C = 16;

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b1;
  logic        ser_rx = 1'b1;
  logic [15:0] checkbits = '0;
  logic        rx_busy, test_started, test_passed;

  tb_uart_if #(.CNT_W(16)) rx_bus ();

  tb_uart #(
    .CLKS_PER_BIT(C),
    .CNT_W       (16)
  ) dut (
    .core_clk    (core_clk),
    .core_rst    (core_rst),
    .ser_rx      (ser_rx),
    .checkbits   (checkbits),
    .rx_bus      (rx_bus),
    .rx_busy     (rx_busy),
    .test_started(test_started),
    .test_passed (test_passed)
  );

  always #5 core_clk = ~core_clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_valid = 0;
  int          n_nl = 0;
  int          n_ferr = 0;
  int          last_valid_cyc = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_count = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge core_clk) cyc++;

  // Output monitor: pops the scoreboard on each valid strobe.
  always @(negedge core_clk) begin
    if (!core_rst) begin
      if (rx_bus.rx_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", 32'(rx_bus.rx_valid), 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check_eq("rx_data", 32'(rx_bus.rx_data), 32'(e));
          check_eq("rx_newline", 32'(rx_bus.rx_newline), 32'(e == 8'h0A));
        end
      end
      if (rx_bus.rx_newline) begin
        n_nl++;
        check_eq("newline_has_valid", 32'(rx_bus.rx_valid), 32'd1);
      end
      if (rx_bus.rx_frame_err) n_ferr++;
    end
  end

  task automatic drive_bit(input logic v);
    ser_rx = v;
    repeat (C) @(negedge core_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back(b);
      exp_count = exp_count + 16'd1;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_valids(input int target, input string tag);
    for (int i = 0; i < 400 && n_valid < target; i++) @(negedge core_clk);
    check_eq(tag, 32'(n_valid), 32'(target));
  endtask

  task automatic do_reset();
    core_rst = 1'b1;
    ser_rx   = 1'b1;
    repeat (2) @(negedge core_clk);
    core_rst = 1'b0;
    exp_count = '0;
    exp_q.delete();
  endtask

  initial begin
    int base;
    int t0;
    int lat;
    int f0;

    repeat (3) @(negedge core_clk);
    // Reset state.
    check_eq("rst_data", 32'(rx_bus.rx_data), 32'd0);
    check_eq("rst_valid", 32'(rx_bus.rx_valid), 32'd0);
    check_eq("rst_ferr", 32'(rx_bus.rx_frame_err), 32'd0);
    check_eq("rst_count", 32'(rx_bus.rx_count), 32'd0);
    check_eq("rst_busy", 32'(rx_busy), 32'd0);
    check_eq("rst_flags", 32'({test_started, test_passed}), 32'd0);
    core_rst = 1'b0;
    repeat (2) @(negedge core_clk);

    // Single character 'A' with latency measurement.
    t0 = cyc;
    send_byte(8'h41, 1'b1);
    wait_valids(1, "a_valids");
    lat = last_valid_cyc - t0;
    check_eq("a_latency", 32'(lat >= 154 && lat <= 156), 32'd1);
    check_eq("a_count", 32'(rx_bus.rx_count), 32'(exp_count));
    check_eq("a_ferr", 32'(n_ferr), 32'd0);

    // "OK\n" back to back after a fresh reset.
    do_reset();
    repeat (C) @(negedge core_clk);
    base = n_valid;
    send_byte(8'h4F, 1'b1);
    send_byte(8'h4B, 1'b1);
    send_byte(ASCII_LF, 1'b1);
    ser_rx = 1'b1;
    wait_valids(base + 3, "ok_valids");
    check_eq("ok_nl_count", 32'(n_nl), 32'd1);
    check_eq("ok_count", 32'(rx_bus.rx_count), 32'(exp_count));

    // Five-cycle low glitch.
    base = n_valid;
    ser_rx = 1'b0;
    repeat (5) @(negedge core_clk);
    ser_rx = 1'b1;
    repeat (3 * C) @(negedge core_clk);
    check_eq("glitch_valids", 32'(n_valid), 32'(base));
    check_eq("glitch_ferr", 32'(n_ferr), 32'd0);
    check_eq("glitch_busy", 32'(rx_busy), 32'd0);
    check_eq("glitch_count", 32'(rx_bus.rx_count), 32'(exp_count));

    // Bad stop bit followed by a 40-bit break, then a good 0x55.
    f0 = n_ferr;
    send_byte(8'hF0, 1'b0);
    ser_rx = 1'b0;
    repeat (40 * C) @(negedge core_clk);
    ser_rx = 1'b1;
    repeat (3 * C) @(negedge core_clk);
    check_eq("brk_ferr", 32'(n_ferr - f0), 32'd1);
    check_eq("brk_valids", 32'(n_valid), 32'(base));
    check_eq("brk_count", 32'(rx_bus.rx_count), 32'(exp_count));
    send_byte(8'h55, 1'b1);
    ser_rx = 1'b1;
    wait_valids(base + 1, "brk_55_valids");
    check_eq("brk_55_count", 32'(rx_bus.rx_count), 32'(exp_count));

    // Checkpoint bus.
    checkbits = 16'h0000;
    repeat (3) @(negedge core_clk);
    check_eq("chk_idle", 32'({test_started, test_passed}), 32'd0);
    checkbits = CHK_STARTED;
    @(negedge core_clk);
    check_eq("chk_started_1", 32'(test_started), 32'd0);
    @(negedge core_clk);
    check_eq("chk_started_2", 32'(test_started), 32'd1);
    checkbits = 16'h1234;
    repeat (3) @(negedge core_clk);
    check_eq("chk_sticky", 32'({test_started, test_passed}), 32'b10);
    checkbits = CHK_PASSED;
    @(negedge core_clk);
    check_eq("chk_passed_1", 32'(test_passed), 32'd0);
    @(negedge core_clk);
    check_eq("chk_passed_2", 32'(test_passed), 32'd1);
    checkbits = 16'h0000;
    repeat (3) @(negedge core_clk);
    check_eq("chk_both", 32'({test_started, test_passed}), 32'b11);

    // Reset in the middle of the data bits of a character.
    base = n_valid;
    f0 = n_ferr;
    ser_rx = 1'b0;
    repeat (C) @(negedge core_clk);
    ser_rx = 1'b1;
    repeat (C) @(negedge core_clk);
    ser_rx = 1'b0;
    repeat (C + C / 2) @(negedge core_clk);
    check_eq("mid_busy", 32'(rx_busy), 32'd1);
    core_rst = 1'b1;
    ser_rx = 1'b1;
    @(negedge core_clk);
    check_eq("mid_rst_data", 32'(rx_bus.rx_data), 32'd0);
    check_eq("mid_rst_count", 32'(rx_bus.rx_count), 32'd0);
    check_eq("mid_rst_busy", 32'(rx_busy), 32'd0);
    check_eq("mid_rst_flags", 32'({test_started, test_passed}), 32'd0);
    check_eq("mid_rst_pulses", 32'({rx_bus.rx_valid, rx_bus.rx_frame_err, rx_bus.rx_newline}),
             32'd0);
    core_rst = 1'b0;
    exp_count = '0;
    exp_q.delete();
    repeat (2 * C) @(negedge core_clk);
    check_eq("mid_no_pulse", 32'(n_valid - base + n_ferr - f0), 32'd0);
    send_byte(8'h33, 1'b1);
    ser_rx = 1'b1;
    wait_valids(base + 1, "mid_33_valids");
    check_eq("mid_33_count", 32'(rx_bus.rx_count), 32'd1);
    check_eq("mid_33_model_count", 32'(rx_bus.rx_count), 32'(exp_count));
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
